// File: rtl/intra_sched_pkg.sv
// Shared types and default sizes for the intra-prediction block scheduler.
`timescale 1ns/1ps
package intra_sched_pkg;

  localparam int FRAMES     = 16;
  localparam int FRAME_PIX  = 1024;
  localparam int BLKS       = 64;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] index;
    logic       mode;
    logic [4:0] qp;
  } param_t;

endpackage

// File: rtl/param_fifo.sv
// Parameter-set queue: circular buffer with a registered occupancy count.
`timescale 1ns/1ps
module param_fifo
  import intra_sched_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  param_t wdata,
  output param_t rdata,
  output logic   empty,
  output logic   ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  param_t           mem_q [DEPTH];
  param_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Readiness comes from the registered count, so a push against a full
  // queue is dropped even when a pop happens in the same cycle.
  assign ready   = cnt_q < CNT_W'(DEPTH);
  assign empty   = (cnt_q == '0);
  assign push_ok = push && ready;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments; comb logic uses blocking.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/intra_sched.sv
// Intra scheduler: loads frames into pixel SRAM, arbitrates engine reads,
// and walks each queued parameter set through all 4x4 blocks of its frame.
`timescale 1ns/1ps
module intra_sched #(
  parameter int FRAMES     = intra_sched_pkg::FRAMES,
  parameter int FRAME_PIX  = intra_sched_pkg::FRAME_PIX,
  parameter int BLKS       = intra_sched_pkg::BLKS,
  parameter int FIFO_DEPTH = intra_sched_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_data,
  input  logic [7:0]  data,
  input  logic        in_valid_param,
  input  logic [3:0]  index,
  input  logic        mode,
  input  logic [4:0]  QP,
  output logic        param_ready,
  output logic        sram_cs,
  output logic        sram_we,
  output logic [13:0] sram_addr,
  output logic [7:0]  sram_wdata,
  input  logic        eng_rd_req,
  input  logic [9:0]  eng_rd_addr,
  output logic        eng_rd_gnt,
  output logic        eng_start,
  output logic [3:0]  eng_frame,
  output logic [5:0]  eng_blk,
  output logic        eng_mode,
  output logic [4:0]  eng_qp,
  input  logic        eng_done,
  output logic        busy,
  output logic        param_done
);
  import intra_sched_pkg::*;

  localparam logic [13:0] LD_LAST  = 14'(FRAMES * FRAME_PIX - 1);
  localparam logic [5:0]  BLK_LAST = 6'(BLKS - 1);

  logic [13:0] ld_cnt_q, ld_cnt_d;
  logic        load_done_q, load_done_d;
  state_t      state_q, state_d;
  param_t      cur_q, cur_d;
  logic [5:0]  blk_q, blk_d;
  param_t      fifo_head;
  logic        fifo_empty;
  logic        fifo_pop;

  param_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid_param),
    .pop   (fifo_pop),
    .wdata (param_t'{index: index, mode: mode, qp: QP}),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .ready (param_ready)
  );

  always_comb begin
    ld_cnt_d    = ld_cnt_q;
    load_done_d = load_done_q;
    if (in_valid_data) begin
      ld_cnt_d = ld_cnt_q + 1'b1;
      if (ld_cnt_q == LD_LAST) begin
        ld_cnt_d    = '0;
        load_done_d = 1'b1;
      end
    end
  end

  // Loader writes always win; the engine holds its request until granted.
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = ld_cnt_q;
    sram_wdata = data;
    eng_rd_gnt = 1'b0;
    if (in_valid_data) begin
      sram_cs = 1'b1;
      sram_we = 1'b1;
    end else if (eng_rd_req) begin
      sram_cs    = 1'b1;
      sram_addr  = {cur_q.index, eng_rd_addr};
      eng_rd_gnt = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    blk_d   = blk_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && load_done_q) begin
          state_d = ST_ISSUE;
          cur_d   = fifo_head;
          blk_d   = '0;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          if (blk_q == BLK_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            blk_d   = blk_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_start  = (state_q == ST_ISSUE);
    param_done = (state_q == ST_DONE);
    fifo_pop   = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q    <= '0;
      load_done_q <= 1'b0;
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      blk_q       <= '0;
    end else begin
      ld_cnt_q    <= ld_cnt_d;
      load_done_q <= load_done_d;
      state_q     <= state_d;
      cur_q       <= cur_d;
      blk_q       <= blk_d;
    end
  end

  assign eng_frame = cur_q.index;
  assign eng_mode  = cur_q.mode;
  assign eng_qp    = cur_q.qp;
  assign eng_blk   = blk_q;

endmodule

// File: tb/tb_intra_sched.sv
// Scoreboard bench for intra_sched: stimulus queues expected SRAM writes and
// block starts, a monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_intra_sched;

  logic        clk;
  logic        rst;
  logic        in_valid_data;
  logic [7:0]  data;
  logic        in_valid_param;
  logic [3:0]  index;
  logic        mode;
  logic [4:0]  QP;
  logic        param_ready;
  logic        sram_cs, sram_we;
  logic [13:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic        eng_rd_req;
  logic [9:0]  eng_rd_addr;
  logic        eng_rd_gnt;
  logic        eng_start;
  logic [3:0]  eng_frame;
  logic [5:0]  eng_blk;
  logic        eng_mode;
  logic [4:0]  eng_qp;
  logic        eng_done;
  logic        busy;
  logic        param_done;

  logic        main_req, eng_req;
  logic [9:0]  main_raddr, eng_raddr;
  assign eng_rd_req  = main_req | eng_req;
  assign eng_rd_addr = main_req ? main_raddr : eng_raddr;

  intra_sched dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_data  (in_valid_data),
    .data           (data),
    .in_valid_param (in_valid_param),
    .index          (index),
    .mode           (mode),
    .QP             (QP),
    .param_ready    (param_ready),
    .sram_cs        (sram_cs),
    .sram_we        (sram_we),
    .sram_addr      (sram_addr),
    .sram_wdata     (sram_wdata),
    .eng_rd_req     (eng_rd_req),
    .eng_rd_addr    (eng_rd_addr),
    .eng_rd_gnt     (eng_rd_gnt),
    .eng_start      (eng_start),
    .eng_frame      (eng_frame),
    .eng_blk        (eng_blk),
    .eng_mode       (eng_mode),
    .eng_qp         (eng_qp),
    .eng_done       (eng_done),
    .busy           (busy),
    .param_done     (param_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] frame;
    logic [5:0] blk;
    logic       mode;
    logic [4:0] qp;
  } start_t;

  start_t      exp_start[$];
  logic [3:0]  exp_done[$];
  logic [21:0] exp_wr[$];
  int          checks = 0;
  int          errors = 0;
  int          accepted_cnt = 0;
  int          done_seen = 0;
  bit          expect_issue = 1'b1;
  bit          spurious_en = 1'b0;
  int          stall_blk = 64;
  logic [3:0]  cur_frame;
  logic [5:0]  cur_blk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every SRAM transaction and every start/done pulse.
  initial begin
    start_t      s;
    logic [21:0] w;
    logic [3:0]  f;
    cur_frame = '0;
    cur_blk   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_frame = '0;
        cur_blk   = '0;
      end else begin
        if (in_valid_data) begin
          check("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check("wr_addr", sram_addr, w[21:8]);
            check("wr_data", sram_wdata, w[7:0]);
            check("wr_cs_we", {sram_cs, sram_we}, 2'b11);
          end
          check("gnt_during_write", eng_rd_gnt, 0);
        end else if (eng_rd_req) begin
          check("rd_gnt", eng_rd_gnt, 1);
          check("rd_cs_we", {sram_cs, sram_we}, 2'b10);
          check("rd_addr", sram_addr, {cur_frame, eng_rd_addr});
        end else begin
          check("sram_idle", {sram_cs, sram_we, eng_rd_gnt}, 0);
        end
        if (eng_start) begin
          check("start_expected", exp_start.size() != 0, 1);
          if (exp_start.size() != 0) begin
            s = exp_start.pop_front();
            check("start_fields", {eng_frame, eng_blk, eng_mode, eng_qp}, s);
            cur_frame = s.frame;
            cur_blk   = s.blk;
          end
        end
        if (busy) check("ctx_stable", {eng_frame, eng_blk}, {cur_frame, cur_blk});
        if (param_done) begin
          check("done_expected", exp_done.size() != 0, 1);
          if (exp_done.size() != 0) begin
            f = exp_done.pop_front();
            check("done_frame", eng_frame, f);
          end
          done_seen++;
        end
      end
    end
  end

  // Engine model: optional read per block, then a done pulse after a random delay.
  initial begin
    eng_done  = 1'b0;
    eng_req   = 1'b0;
    eng_raddr = '0;
    forever begin
      @(negedge clk);
      if (spurious_en && !busy && $urandom_range(3, 0) == 0) begin
        @(posedge clk); #1 eng_done = 1'b1;
        @(posedge clk); #1 eng_done = 1'b0;
      end else if (eng_start && !rst && int'(eng_blk) != stall_blk) begin
        if ($urandom_range(1, 0) == 1) begin
          @(posedge clk); #1;
          eng_req   = 1'b1;
          eng_raddr = 10'($urandom);
          for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (eng_rd_gnt) break;
          end
          @(posedge clk); #1 eng_req = 1'b0;
        end
        repeat ($urandom_range(3, 0)) @(posedge clk);
        @(posedge clk); #1 eng_done = 1'b1;
        @(posedge clk); #1 eng_done = 1'b0;
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic push_param(input logic [3:0] f, input logic m, input logic [4:0] q);
    bit exp_rdy;
    exp_rdy = (accepted_cnt - done_seen) < 4;
    in_valid_param = 1'b1;
    index = f;
    mode  = m;
    QP    = q;
    @(negedge clk);
    check("param_ready", param_ready, exp_rdy);
    if (exp_rdy) begin
      accepted_cnt++;
      if (expect_issue) begin
        for (int b = 0; b < 64; b++) exp_start.push_back({f, 6'(b), m, q});
        exp_done.push_back(f);
      end
    end
    @(posedge clk); #1;
    in_valid_param = 1'b0;
  endtask

  task automatic write_byte(input logic [13:0] a);
    in_valid_data = 1'b1;
    data = a[7:0];
    exp_wr.push_back({a, a[7:0]});
    @(posedge clk); #1;
    in_valid_data = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || exp_start.size() != 0 || exp_done.size() != 0) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check({"idle_reached_", tag}, n < 20000, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    int n;
    rst = 1'b1;
    in_valid_data = 1'b0;
    data = '0;
    in_valid_param = 1'b0;
    index = '0;
    mode = 1'b0;
    QP = '0;
    main_req = 1'b0;
    main_raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", param_ready, 1);
    check("rst_outputs", {eng_start, param_done, eng_frame, eng_blk, eng_mode, eng_qp}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // A set queued before the load completes must wait for load_done.
    push_param(4'd1, 1'b0, 5'd5);

    for (int i = 0; i < 16385; i++) begin
      if (i == 16383) begin
        @(negedge clk);
        check("busy_before_load_done", busy, 0);
        @(posedge clk); #1;
      end
      if (i == 5) begin
        main_req   = 1'b1;
        main_raddr = 10'd9;
      end
      write_byte(14'(i));
      if (i == 5) begin
        @(negedge clk);
        check("held_read_granted", eng_rd_gnt, 1);
        check("held_read_addr", sram_addr, {4'd0, 10'd9});
        @(posedge clk); #1;
        main_req = 1'b0;
      end
      if ($urandom_range(31, 0) == 0) begin
        @(posedge clk); #1;
      end
    end
    wait_idle("load");

    // Latency from push to first start, then a full 64-block pass.
    d0 = done_seen;
    push_param(4'd3, 1'b1, 5'd28);
    @(negedge clk);
    check("lat_t1_no_start", eng_start, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_t2_start", eng_start, 1);
    check("lat_frame_mode_qp", {eng_frame, eng_mode, eng_qp}, {4'd3, 1'b1, 5'd28});
    @(posedge clk); #1;
    wait_idle("single");
    check("single_done_cnt", done_seen - d0, 1);
    check("single_busy_fell", busy, 0);

    // Five back-to-back pushes: fifth hits a full queue.
    d0 = done_seen;
    for (int k = 0; k < 5; k++)
      push_param(4'($urandom), 1'($urandom), 5'($urandom));
    wait_idle("burst");
    check("burst_done_cnt", done_seen - d0, 4);

    // Stray done pulses while idle must not start anything.
    spurious_en = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    spurious_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("spurious_busy", busy, 0);

    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(60, 0)) @(posedge clk);
      #1;
      push_param(4'($urandom), 1'($urandom), 5'($urandom));
    end
    wait_idle("random");

    // Reset while waiting on block 17.
    stall_blk = 17;
    push_param(4'($urandom_range(15, 1)), 1'b1, 5'($urandom));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && eng_blk == 6'd17 && !eng_start) && n < 5000);
    check("reached_blk17_wait", busy && eng_blk == 6'd17, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_start.delete();
    exp_done.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    accepted_cnt = 0;
    done_seen = 0;
    expect_issue = 1'b0;
    stall_blk = 64;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", param_ready, 1);
    check("post_rst_ctx", {eng_frame, eng_blk, eng_mode, eng_qp}, 0);
    check("post_rst_no_done", param_done, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++)
      push_param(4'($urandom), 1'($urandom), 5'($urandom));
    repeat (30) @(posedge clk);
    #1;
    check("no_issue_without_load", busy, 0);
    check("no_done_after_rst", done_seen, 0);
    check("wr_queue_drained", exp_wr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intra_sched.md
INTRA_SCHED -- requirements
Module: intra_sched

Interface
REQ-001 Parameters SHALL be: FRAMES, default 16, frames held in pixel SRAM.
REQ-002 FRAME_PIX, default 1024, pixels per frame (32x32).
REQ-003 BLKS, default 64, 4x4 blocks per frame.
REQ-004 FIFO_DEPTH, default 4, parameter-set queue depth.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high. Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid_data  in  1  pixel byte valid
data  in  8  pixel byte, raster order, frame 0 first
in_valid_param  in  1  parameter set valid
index  in  4  target frame
mode  in  1  prediction mode
QP  in  5  quantization parameter
param_ready  out  1  queue not full
sram_cs  out  1  SRAM select
sram_we  out  1  SRAM write enable
sram_addr  out  14  {frame[3:0], pixel[9:0]}
sram_wdata  out  8  write byte
eng_rd_req  in  1  engine read request
eng_rd_addr  in  10  pixel address within current frame
eng_rd_gnt  out  1  engine read granted this cycle
eng_start  out  1  one-cycle block start pulse
eng_frame  out  4  current frame
eng_blk  out  6  current 4x4 block index
eng_mode  out  1  current mode
eng_qp  out  5  current QP
eng_done  in  1  engine finished current block (pulse)
busy  out  1  FSM not in IDLE
param_done  out  1  one-cycle pulse, parameter set fully processed

Function
REQ-006 Loader: 14-bit counter ld_cnt; each in_valid_data cycle writes data at ld_cnt, then ld_cnt+1; 16383 wraps to 0 and sets load_done (sticky until rst).
REQ-007 SRAM arbitration (combinational, same cycle): in_valid_data wins -> cs=1, we=1, addr=ld_cnt, wdata=data; else eng_rd_req -> cs=1, we=0, addr={eng_frame, eng_rd_addr}, eng_rd_gnt=1; else cs=0, we=0.
REQ-008 eng_rd_gnt SHALL be 0 whenever in_valid_data=1; engine holds request until granted.
REQ-009 Queue: push {index, mode, QP} when in_valid_param=1 and param_ready=1; param_ready = registered occupancy < FIFO_DEPTH.
REQ-010 Push while full SHALL be dropped, even if a pop occurs in the same cycle; push and pop in the same cycle when not full SHALL both take effect.
REQ-011 FSM states IDLE, ISSUE, WAIT, DONE.
REQ-012 IDLE -> ISSUE when queue non-empty and load_done=1; head latched into eng_frame/eng_mode/eng_qp, eng_blk=0.
REQ-013 ISSUE: eng_start=1 for exactly this cycle -> WAIT.
REQ-014 WAIT: on eng_done, if eng_blk=63 -> DONE, else eng_blk+1 -> ISSUE; otherwise stay.
REQ-015 DONE: param_done=1 one cycle, queue popped -> IDLE.
REQ-016 eng_done outside WAIT SHALL be ignored.
REQ-017 Latency: param pushed at edge t into empty queue with load_done=1 -> eng_start high in cycle t+2.
REQ-018 eng_frame/eng_blk/eng_mode/eng_qp SHALL be stable from ISSUE until WAIT exits.
REQ-019 busy = (state != IDLE).

Reset
REQ-020 rst high at a rising edge SHALL clear: state=IDLE, ld_cnt=0, load_done=0, queue empty, eng_frame/eng_blk/eng_mode/eng_qp=0, eng_start=0, param_done=0; param_ready=1 after the edge.
REQ-021 Reset mid-operation SHALL abandon the current set without param_done; SRAM contents are not cleared.

Structure
REQ-022 Package intra_sched_pkg SHALL hold the state enum, FRAMES/FRAME_PIX/BLKS/FIFO_DEPTH constants and the param-set struct {index, mode, QP}.
REQ-023 Queue SHALL be sub-module param_fifo (synchronous, registered count, same reset).

Verification
REQ-024 Load 16384 bytes data=addr[7:0] -> writes at addr 0..16383, load_done after last; byte 16385 writes addr 0.
REQ-025 in_valid_data and eng_rd_req both high with ld_cnt=5, eng_rd_addr=9 -> addr=5, we=1, gnt=0; next cycle data idle -> addr={eng_frame,9}, gnt=1.
REQ-026 Params (index=3,mode=1,QP=28) pushed at t after load -> eng_start at t+2, eng_frame=3, eng_qp=28; 64 eng_done pulses -> eng_blk 0..63, one param_done, busy falls.
REQ-027 Five pushes back-to-back while busy -> param_ready low after fourth; fifth dropped; exactly four param_done pulses total.
REQ-028 rst asserted in WAIT at eng_blk=17 -> next cycle IDLE, busy=0, queue empty, load_done=0, no param_done.
